// File: rtl/pipelined_rca_adder_if.sv
// Valid/ready operand and result bundle for pipelined_rca_adder.
// RCA_SUB_EN adds the sub select alongside the operands.
interface pipelined_rca_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef RCA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin,
`ifdef RCA_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef RCA_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: STAGES chunks of WIDTH/STAGES bits.
// Optional RCA_SUB_EN: sub=1 computes a + ~b + 1, captured with operands.
module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_rca_adder_if.slave io
);
  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("WIDTH must be a multiple of STAGES");
  end

  function automatic logic [CHUNK:0] rca(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c
  );
    logic [CHUNK:0] r;
    logic           cy;
    r  = '0;
    cy = c;
    for (int i = 0; i < CHUNK; i++) begin
      r[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    r[CHUNK] = cy;
    return r;
  endfunction

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [CHUNK:0]    chunk_r [STAGES];
  logic [STAGES:0]   ready;
  logic [WIDTH-1:0]  b_in;
  logic              c_in;

  // Subtract folds into the operands once at entry.
  always_comb begin
`ifdef RCA_SUB_EN
    b_in = io.sub ? ~io.b : io.b;
    c_in = io.sub ? 1'b1 : io.cin;
`else
    b_in = io.b;
    c_in = io.cin;
`endif
  end

  always_comb begin
    ready[STAGES] = io.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = ~valid_q[k] | ready[k+1];
    end

    chunk_r[0] = rca(io.a[CHUNK-1:0], b_in[CHUNK-1:0], c_in);
    for (int k = 1; k < STAGES; k++) begin
      chunk_r[k] = rca(a_q[k-1][k*CHUNK +: CHUNK],
                       b_q[k-1][k*CHUNK +: CHUNK],
                       carry_q[k-1]);
    end

    valid_d = valid_q;
    carry_d = carry_q;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = sum_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
    end

    if (ready[0]) begin
      valid_d[0] = io.in_valid;
      if (io.in_valid) begin
        sum_d[0]            = '0;
        sum_d[0][CHUNK-1:0] = chunk_r[0][CHUNK-1:0];
        carry_d[0]          = chunk_r[0][CHUNK];
        a_d[0]              = io.a;
        b_d[0]              = b_in;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (ready[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          sum_d[k] = sum_q[k-1];
          sum_d[k][k*CHUNK +: CHUNK] = chunk_r[k][CHUNK-1:0];
          carry_d[k] = chunk_r[k][CHUNK];
          a_d[k]     = a_q[k-1];
          b_d[k]     = b_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  // Last stage operands are fully consumed; keep them as a lint sink.
  logic unused_ok;
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign io.in_ready  = ready[0];
  assign io.out_valid = valid_q[STAGES-1];
  assign io.sum       = sum_q[STAGES-1];
  assign io.cout      = carry_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Bench for pipelined_rca_adder: arithmetic model + FIFO scoreboard.
// Define RCA_SUB_EN to also exercise subtraction.
module tb_pipelined_rca_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sub_v = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int run = 0;
  int last_run = 0;

  logic [W:0] exp_q[$];
  logic       have_hold = 1'b0;
  logic [W:0] held;

  pipelined_rca_adder_if #(.WIDTH(W)) io ();

`ifdef RCA_SUB_EN
  assign io.sub = sub_v;
`endif

  pipelined_rca_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(
    logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
    if (s) return 17'h10000 + {1'b0, x} - {1'b0, y};
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every result seen must be the oldest accepted operand set.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_hold = 1'b0;
      run = 0;
    end else begin
      if (have_hold) begin
        chk("stall_valid", {31'd0, io.out_valid}, 32'd1);
        chk("stall_data", {15'd0, io.cout, io.sum}, {15'd0, held});
      end
      if (io.out_valid) begin
        run++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          chk("result", {15'd0, io.cout, io.sum}, {15'd0, exp_q[0]});
          if (io.out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      have_hold = io.out_valid & ~io.out_ready;
      held = {io.cout, io.sum};
      if (io.in_valid && io.in_ready)
        exp_q.push_back(model(io.a, io.b, io.cin, sub_v));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [W-1:0] x, logic [W-1:0] y,
                      logic c, logic s);
    logic ok;
    ok = 1'b0;
    io.a = x; io.b = y; io.cin = c; sub_v = s;
    io.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = io.in_ready;
      tick();
    end
    io.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(string name, logic [W-1:0] es, logic ec);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = io.out_valid;
    end
    chk({name, "_seen"}, {31'd0, seen}, 32'd1);
    chk({name, "_sum"}, {16'd0, io.sum}, {16'd0, es});
    chk({name, "_cout"}, {31'd0, io.cout}, {31'd0, ec});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    io.a = '0; io.b = '0; io.cin = 1'b0;

    #3;
    chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_sum", {16'd0, io.sum}, 32'd0);
    chk("rst_cout", {31'd0, io.cout}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);

    // Test 1: exact latency of a single transfer.
    io.a = 16'h0001; io.b = 16'h0000; io.cin = 1'b0;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    for (int i = 0; i < S - 1; i++) begin
      @(negedge clk);
      chk("t1_early", {31'd0, io.out_valid}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("t1_valid", {31'd0, io.out_valid}, 32'd1);
    chk("t1_sum", {16'd0, io.sum}, 32'h0001);
    chk("t1_cout", {31'd0, io.cout}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_drop", {31'd0, io.out_valid}, 32'd0);
    tick();

    // Test 2: carry across every chunk, then with cin.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out("t2a", 16'h0000, 1'b1);
    send(16'h00FF, 16'h0001, 1'b1, 1'b0);
    wait_out("t2b", 16'h0101, 1'b0);

    // Test 3: eight back-to-back transfers.
    for (int i = 0; i < 8; i++) begin
      io.a = W'($urandom); io.b = W'($urandom);
      io.cin = 1'($urandom); sub_v = 1'b0;
      io.in_valid = 1'b1;
      @(negedge clk);
      chk("t3_in_ready", {31'd0, io.in_ready}, 32'd1);
      tick();
    end
    io.in_valid = 1'b0;
    repeat (10) tick();
    chk("t3_run", last_run, 8);

    // Test 4: stalled output fills the pipe with exactly S results.
    io.out_ready = 1'b0;
    acc = 0;
    base = n_out;
    for (int i = 0; i < 10; i++) begin
      io.a = W'($urandom); io.b = W'($urandom);
      io.cin = 1'($urandom);
      io.in_valid = 1'b1;
      @(negedge clk);
      if (io.in_ready) acc++;
      tick();
    end
    chk("t4_accepted", acc, S);
    @(negedge clk);
    chk("t4_full", {31'd0, io.in_ready}, 32'd0);
    tick();
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    repeat (10) tick();
    chk("t4_drained", n_out - base, S);
    chk("t4_queue", exp_q.size(), 0);

    // Test 5: async reset with results in flight.
    for (int i = 0; i < 3; i++) begin
      io.a = W'($urandom); io.b = W'($urandom);
      io.cin = 1'($urandom);
      io.in_valid = 1'b1;
      tick();
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("t5_pre", {31'd0, io.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_async", {31'd0, io.out_valid}, 32'd0);
    chk("t5_sum", {16'd0, io.sum}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    io.out_ready = 1'b1;
    base = n_out;
    @(negedge clk);
    chk("t5_in_ready", {31'd0, io.in_ready}, 32'd1);
    repeat (10) tick();
    chk("t5_no_stale", n_out - base, 0);

`ifdef RCA_SUB_EN
    // Test 6: subtraction with and without borrow.
    send(16'h0005, 16'h0003, 1'b0, 1'b1);
    wait_out("t6a", 16'h0002, 1'b1);
    send(16'h0003, 16'h0005, 1'b1, 1'b1);
    wait_out("t6b", 16'hFFFE, 1'b0);
`endif

    // Random soak with random backpressure.
    for (int i = 0; i < 400; i++) begin
      io.a = W'($urandom); io.b = W'($urandom);
      io.cin = 1'($urandom);
`ifdef RCA_SUB_EN
      sub_v = 1'($urandom);
`endif
      io.in_valid = ($urandom % 4) != 0;
      io.out_ready = ($urandom % 3) != 0;
      tick();
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    repeat (12) tick();
    chk("soak_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
